mem_trace_collector: RTL and testbench

Multi-channel memory-transaction trace collector, the parametrised successor to the fixed IF/ID/EX/WB trace chain. It observes NUM_CH independent request/grant/rvalid memory ports (e.g. channel 0 = instruction port, channel 1 = data port), timestamps each transaction phase against a free-running cycle counter, and queues one completed record per transaction into a DEPTH-entry FIFO. The FIFO drains through a valid/ready stream to the trace sink. Records that cannot be stored are counted, never silently lost.

---
 rtl/mem_trace_collector.sv | 217 +++++++++++++++++++++
 tb/tb_mem_trace_collector.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_trace_collector.sv
`default_nettype none
// mem_trace_collector: per-channel req/gnt/rvalid transaction tracer with
// timestamped records merged into a single drop-counted output FIFO.
module mem_trace_collector #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int TS_WIDTH   = 32,
  parameter int DEPTH      = 16,
  parameter int DROP_WIDTH = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         trace_en,
  input  logic [NUM_CH-1:0]                            mem_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [NUM_CH-1:0]                            mem_gnt,
  input  logic [NUM_CH-1:0]                            mem_rvalid,
  output logic                                         trace_valid,
  input  logic                                         trace_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] trace_ch,
  output logic [ADDR_WIDTH-1:0]                        trace_addr,
  output logic [TS_WIDTH-1:0]                          trace_t_req,
  output logic [TS_WIDTH-1:0]                          trace_t_gnt,
  output logic [TS_WIDTH-1:0]                          trace_t_rvalid,
  output logic [$clog2(DEPTH+1)-1:0]                   fifo_level,
  output logic [DROP_WIDTH-1:0]                        drop_count
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PREC_W = ADDR_WIDTH + 3 * TS_WIDTH;
  localparam int REC_W  = CH_W + PREC_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RV  = 2'd2
  } state_t;

  logic [TS_WIDTH-1:0] ts;
  logic [NUM_CH-1:0]   pend_valid;
  logic [NUM_CH-1:0]   complete;
  logic [NUM_CH-1:0]   drop;
  logic [NUM_CH-1:0]   grant;
  logic [PREC_W-1:0]   pend_rec [NUM_CH];

  logic                push;
  logic                pop;
  logic                full;
  logic [CH_W-1:0]     sel;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [REC_W-1:0]    fifo_mem [DEPTH];
  logic [REC_W-1:0]    head;

  logic [3:0]            n_drop;
  logic [DROP_WIDTH:0]   drop_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                  req;
    logic                  gnt;
    logic                  rv;
    logic                  start;
    logic [ADDR_WIDTH-1:0] addr;
    state_t                state;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [TS_WIDTH-1:0]   cap_treq;
    logic [TS_WIDTH-1:0]   cap_tgnt;
    logic                  pv;
    logic [PREC_W-1:0]     prec;

    assign req   = mem_req[i];
    assign gnt   = mem_gnt[i];
    assign rv    = mem_rvalid[i];
    assign addr  = mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign start = req && trace_en;

    assign complete[i] = (state == ST_WAIT_RV) && rv;
    // A slot being drained this cycle may be refilled on the same edge.
    assign drop[i]       = complete[i] && pv && !grant[i];
    assign pend_valid[i] = pv;
    assign pend_rec[i]   = prec;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= ST_IDLE;
        cap_addr <= '0;
        cap_treq <= '0;
        cap_tgnt <= '0;
        pv       <= 1'b0;
        prec     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cap_addr <= addr;
              cap_treq <= ts;
              cap_tgnt <= ts;
              state    <= gnt ? ST_WAIT_RV : ST_WAIT_GNT;
            end
          end
          ST_WAIT_GNT: begin
            if (gnt) begin
              cap_tgnt <= ts;
              state    <= ST_WAIT_RV;
            end
          end
          ST_WAIT_RV: begin
            if (rv) begin
              if (start) begin
                cap_addr <= addr;
                cap_treq <= ts;
                cap_tgnt <= ts;
                state    <= gnt ? ST_WAIT_RV : ST_WAIT_GNT;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase

        if (grant[i]) begin
          pv <= 1'b0;
        end
        if (complete[i] && !drop[i]) begin
          pv   <= 1'b1;
          prec <= {cap_addr, cap_treq, cap_tgnt, ts};
        end
      end
    end
  end

  assign full = (level == LVL_W'(DEPTH));
  assign pop  = trace_valid && trace_ready;

  // Fixed priority: the lowest-numbered pending channel wins.
  always_comb begin
    grant = '0;
    sel   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pend_valid[k]) begin
        sel = CH_W'(k);
      end
    end
    push = (|pend_valid) && (!full || pop);
    if (push) begin
      grant[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {sel, pend_rec[sel]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    n_drop = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      n_drop = n_drop + 4'(drop[k]);
    end
    drop_sum = {1'b0, drop_count} + (DROP_WIDTH + 1)'(n_drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_sum[DROP_WIDTH]) begin
      drop_count <= '1;
    end else begin
      drop_count <= drop_sum[DROP_WIDTH-1:0];
    end
  end

  // Head fields read as zero whenever the FIFO is empty, including after reset.
  assign trace_valid    = (level != '0);
  assign fifo_level     = level;
  assign head           = fifo_mem[rd_ptr];
  assign trace_ch       = trace_valid ? head[REC_W-1 -: CH_W] : '0;
  assign trace_addr     = trace_valid ? head[PREC_W-1 -: ADDR_WIDTH] : '0;
  assign trace_t_req    = trace_valid ? head[3*TS_WIDTH-1 -: TS_WIDTH] : '0;
  assign trace_t_gnt    = trace_valid ? head[2*TS_WIDTH-1 -: TS_WIDTH] : '0;
  assign trace_t_rvalid = trace_valid ? head[TS_WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_trace_collector.sv
`default_nettype none
// tb_mem_trace_collector: directed scenario tests with hand-computed records.
module tb_mem_trace_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_en = 1'b1;
  logic [1:0]  mem_req = '0;
  logic [63:0] mem_addr = '0;
  logic [1:0]  mem_gnt = '0;
  logic [1:0]  mem_rvalid = '0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [0:0]  trace_ch;
  logic [31:0] trace_addr;
  logic [31:0] trace_t_req;
  logic [31:0] trace_t_gnt;
  logic [31:0] trace_t_rvalid;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  mem_trace_collector #(
    .NUM_CH(2), .ADDR_WIDTH(32), .TS_WIDTH(32), .DEPTH(16), .DROP_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_ch(trace_ch),
    .trace_addr(trace_addr), .trace_t_req(trace_t_req), .trace_t_gnt(trace_t_gnt),
    .trace_t_rvalid(trace_t_rvalid), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic idle_inputs();
    mem_req = '0;
    mem_gnt = '0;
    mem_rvalid = '0;
    mem_addr = '0;
    trace_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({trace_valid, fifo_level, drop_count, trace_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%0b level=%0d drop=%0d addr=%0h, need all 0",
               trace_valid, fifo_level, drop_count, trace_addr);
    end
    tick();
    rst = 1'b0;
    cyc = 0;
    tick();
    n_checks++;
    if ({trace_valid, fifo_level, trace_t_req} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%0b level=%0d t_req=%0d, need all 0",
               trace_valid, fifo_level, trace_t_req);
    end
  endtask

  task automatic test_single_ch0();
    wait_until(5);
    mem_req[0] = 1'b1; mem_gnt[0] = 1'b1; mem_addr[31:0] = 32'h100;
    tick();
    mem_req[0] = 1'b0; mem_gnt[0] = 1'b0; mem_addr[31:0] = 32'h0;
    tick();
    mem_rvalid[0] = 1'b1;
    tick();
    mem_rvalid[0] = 1'b0;
    n_checks++;
    if (trace_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_latency: valid=%0b at cycle 8, need 0", trace_valid);
    end
    tick();
    n_checks++;
    if ({trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid, fifo_level}
        !== {1'b1, 1'b0, 32'h100, 32'd5, 32'd5, 32'd7, 5'd1}) begin
      n_fail++;
      $display("FAIL t1_record: got v=%0b ch=%0d addr=%0h t=%0d/%0d/%0d lvl=%0d, need v=1 ch=0 addr=100 t=5/5/7 lvl=1",
               trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid, fifo_level);
    end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    n_checks++;
    if ({trace_valid, fifo_level} !== 6'd0) begin
      n_fail++;
      $display("FAIL t1_pop: valid=%0b level=%0d, need 0/0", trace_valid, fifo_level);
    end
  endtask

  task automatic test_wait_gnt_ch1();
    wait_until(10);
    mem_req[1] = 1'b1; mem_addr[63:32] = 32'h2000;
    tick();
    mem_addr[63:32] = 32'hDEAD;
    wait_until(13);
    mem_gnt[1] = 1'b1;
    tick();
    mem_req[1] = 1'b0; mem_gnt[1] = 1'b0; mem_rvalid[1] = 1'b1;
    tick();
    mem_rvalid[1] = 1'b0;
    tick();
    n_checks++;
    if ({trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid}
        !== {1'b1, 1'b1, 32'h2000, 32'd10, 32'd13, 32'd14}) begin
      n_fail++;
      $display("FAIL t2_record: got v=%0b ch=%0d addr=%0h t=%0d/%0d/%0d, need v=1 ch=1 addr=2000 t=10/13/14",
               trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid);
    end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
  endtask

  task automatic test_both_channels();
    wait_until(20);
    trace_ready = 1'b1;
    mem_req = 2'b11; mem_gnt = 2'b11; mem_addr = {32'h31, 32'h30};
    tick();
    mem_req = 2'b00; mem_gnt = 2'b00; mem_rvalid = 2'b11;
    tick();
    mem_rvalid = 2'b00;
    tick();
    n_checks++;
    if ({trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_rvalid}
        !== {1'b1, 1'b0, 32'h30, 32'd20, 32'd21}) begin
      n_fail++;
      $display("FAIL t3_first: got v=%0b ch=%0d addr=%0h t_req=%0d t_rv=%0d, need v=1 ch=0 addr=30 20/21",
               trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_rvalid);
    end
    tick();
    n_checks++;
    if ({trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_rvalid}
        !== {1'b1, 1'b1, 32'h31, 32'd20, 32'd21}) begin
      n_fail++;
      $display("FAIL t3_second: got v=%0b ch=%0d addr=%0h t_req=%0d t_rv=%0d, need v=1 ch=1 addr=31 20/21",
               trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_rvalid);
    end
    tick();
    trace_ready = 1'b0;
    n_checks++;
    if ({trace_valid, drop_count} !== 17'd0) begin
      n_fail++;
      $display("FAIL t3_drained: valid=%0b drop=%0d, need 0/0", trace_valid, drop_count);
    end
  endtask

  task automatic test_back_to_back_overflow();
    wait_until(30);
    for (int k = 0; k <= 20; k++) begin
      mem_req[0]     = (k < 20);
      mem_gnt[0]     = (k < 20);
      mem_rvalid[0]  = (k >= 1);
      mem_addr[31:0] = 32'h4000 + 32'(k);
      tick();
    end
    idle_inputs();
    wait_until(52);
    n_checks++;
    if ({fifo_level, drop_count} !== {5'd16, 16'd3}) begin
      n_fail++;
      $display("FAIL t4_full: level=%0d drop=%0d, need 16/3", fifo_level, drop_count);
    end
    trace_ready = 1'b1;
    for (int j = 0; j < 17; j++) begin
      n_checks++;
      if ({trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid}
          !== {1'b1, 1'b0, 32'h4000 + 32'(j), 32'(30 + j), 32'(30 + j), 32'(31 + j)}) begin
        n_fail++;
        $display("FAIL t4_drain[%0d]: got v=%0b ch=%0d addr=%0h t=%0d/%0d/%0d, need v=1 ch=0 addr=%0h t=%0d/%0d/%0d",
                 j, trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid,
                 32'h4000 + 32'(j), 30 + j, 30 + j, 31 + j);
      end
      tick();
    end
    trace_ready = 1'b0;
    n_checks++;
    if ({trace_valid, fifo_level, drop_count} !== {1'b0, 5'd0, 16'd3}) begin
      n_fail++;
      $display("FAIL t4_empty: valid=%0b level=%0d drop=%0d, need 0/0/3",
               trace_valid, fifo_level, drop_count);
    end
  endtask

  task automatic test_async_reset();
    wait_until(72);
    for (int k = 0; k <= 5; k++) begin
      mem_req[0]     = (k < 5);
      mem_gnt[0]     = (k < 5);
      mem_rvalid[0]  = (k >= 1);
      mem_addr[31:0] = 32'h7000 + 32'(k);
      if (k == 5) begin
        mem_req[1] = 1'b1; mem_addr[63:32] = 32'h777;
      end
      tick();
    end
    idle_inputs();
    wait_until(79);
    n_checks++;
    if ({trace_valid, fifo_level} !== {1'b1, 5'd5}) begin
      n_fail++;
      $display("FAIL t5_prefill: valid=%0b level=%0d, need 1/5", trace_valid, fifo_level);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({trace_valid, fifo_level, drop_count, trace_addr} !== '0) begin
      n_fail++;
      $display("FAIL t5_async: valid=%0b level=%0d drop=%0d addr=%0h, need all 0",
               trace_valid, fifo_level, drop_count, trace_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    tick();
    mem_gnt[1] = 1'b1;
    tick();
    mem_gnt[1] = 1'b0; mem_rvalid[1] = 1'b1;
    tick();
    mem_rvalid[1] = 1'b0;
    mem_req[0] = 1'b1; mem_gnt[0] = 1'b1; mem_addr[31:0] = 32'h500;
    tick();
    mem_req[0] = 1'b0; mem_gnt[0] = 1'b0; mem_rvalid[0] = 1'b1;
    tick();
    mem_rvalid[0] = 1'b0;
    n_checks++;
    if ({trace_valid, fifo_level} !== 6'd0) begin
      n_fail++;
      $display("FAIL t5_stale: valid=%0b level=%0d at cycle 5, need 0/0", trace_valid, fifo_level);
    end
    tick();
    n_checks++;
    if ({trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid, fifo_level}
        !== {1'b1, 1'b0, 32'h500, 32'd3, 32'd3, 32'd4, 5'd1}) begin
      n_fail++;
      $display("FAIL t5_restart: got v=%0b ch=%0d addr=%0h t=%0d/%0d/%0d lvl=%0d, need v=1 ch=0 addr=500 t=3/3/4 lvl=1",
               trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid, fifo_level);
    end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
  endtask

  task automatic test_trace_en();
    wait_until(10);
    trace_en = 1'b1;
    mem_req[1] = 1'b1; mem_addr[63:32] = 32'h600;
    tick();
    trace_en = 1'b0; mem_addr[63:32] = 32'hBAD;
    tick();
    mem_gnt[1] = 1'b1;
    tick();
    mem_req[1] = 1'b0; mem_gnt[1] = 1'b0; mem_rvalid[1] = 1'b1;
    tick();
    mem_rvalid[1] = 1'b0;
    tick();
    n_checks++;
    if ({trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid}
        !== {1'b1, 1'b1, 32'h600, 32'd10, 32'd12, 32'd13}) begin
      n_fail++;
      $display("FAIL t6_inflight: got v=%0b ch=%0d addr=%0h t=%0d/%0d/%0d, need v=1 ch=1 addr=600 t=10/12/13",
               trace_valid, trace_ch, trace_addr, trace_t_req, trace_t_gnt, trace_t_rvalid);
    end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    wait_until(20);
    mem_req[0] = 1'b1; mem_gnt[0] = 1'b1; mem_addr[31:0] = 32'h999;
    tick();
    mem_req[0] = 1'b0; mem_gnt[0] = 1'b0; mem_rvalid[0] = 1'b1;
    tick();
    mem_rvalid[0] = 1'b0;
    wait_until(24);
    n_checks++;
    if ({trace_valid, fifo_level} !== 6'd0) begin
      n_fail++;
      $display("FAIL t6_disabled: valid=%0b level=%0d, need 0/0", trace_valid, fifo_level);
    end
    trace_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_ch0();
    test_wait_gnt_ch1();
    test_both_channels();
    test_back_to_back_overflow();
    test_async_reset();
    test_trace_en();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
